// File: rtl/gpu_pkg.sv
// Shared GPU definitions: transfer counter width, read FIFO depth and the
// packed pixel-pair word moved between VRAM and the CPU.
package gpu_pkg;

  localparam int GPU_XFER_CNT_W      = 20;
  localparam int GPU_READ_FIFO_DEPTH = 16;

  // Two 16-bit pixels per 32-bit word; lo is the left pixel.
  typedef struct packed {
    logic [15:0] hi;
    logic [15:0] lo;
  } pixel_pair_t;

endpackage

// File: rtl/gpu_sync_fifo.sv
// Generic single-clock FIFO with a registered read port and an occupancy
// output. Pointers wrap modulo DEPTH; the level is tracked separately so
// full and empty are both representable (DEPTH+1 states).
//
// Handshake: a word is written when i_push is high and o_can_push is high in
// the same cycle. o_can_push comes from registered state only and does not
// look at i_push, nor at a pop in the same cycle (no full-bypass). A pop is
// taken when i_pop is high and the level is non-zero; the head word appears
// on o_rdata after the edge, otherwise o_rdata holds. i_clr empties the FIFO
// and discards any push/pop in that cycle, keeping o_rdata.
module gpu_sync_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 32
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_clr,
  input  logic                     i_push,
  input  logic [W-1:0]             i_wdata,
  output logic                     o_can_push,
  input  logic                     i_pop,
  output logic [W-1:0]             o_rdata,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [LW-1:0] level;
  logic          do_push;
  logic          do_pop;

  assign o_can_push = (level != LW'(DEPTH));
  assign o_empty    = (level == '0);
  assign o_level    = level;

  // Effective push/pop after full/empty qualification and clear.
  always_comb begin
    do_push = i_push && o_can_push && !i_clr;
    do_pop  = i_pop && !o_empty && !i_clr;
  end

  // Pointer and level bookkeeping.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  // Storage array; no reset so it maps onto plain RAM.
  always_ff @(posedge i_clk) begin
    if (do_push && !i_rst) mem[wr_ptr] <= i_wdata;
  end

  // Registered read port: loads the head word on a pop, holds otherwise.
  always_ff @(posedge i_clk) begin
    if (i_rst)       o_rdata <= '0;
    else if (do_pop) o_rdata <= mem[rd_ptr];
  end

endmodule

// File: rtl/gpu_vramcpu_read_fifo.sv
// VRAM->CPU read path: buffers pixel pairs from the copy engine, serves
// GPUREAD strobes, counts down the words of the active transfer and drives
// the ready-to-send status bit, the transfer-done pulse and a sticky
// underflow flag.
//
// Engine side: a pair is taken when i_pairValid && o_pairAccept.
// CPU side: i_cpuRead is a one-cycle strobe; data shows on o_cpuData one
// cycle later if the FIFO was non-empty. Flush or start in a cycle discards
// any push or read presented in that cycle.
module gpu_vramcpu_read_fifo
  import gpu_pkg::*;
#(
  parameter int DEPTH = GPU_READ_FIFO_DEPTH,
  parameter int CNT_W = GPU_XFER_CNT_W
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_xferStart,
  input  logic [CNT_W-1:0]       i_xferWords,
  input  logic                   i_flush,
  input  logic                   i_pairValid,
  input  logic [31:0]            i_pairData,
  output logic                   o_pairAccept,
  input  logic                   i_cpuRead,
  output logic [31:0]            o_cpuData,
  output logic                   o_readReady,
  output logic                   o_xferDone,
  output logic                   o_underflow,
  output logic [$clog2(DEPTH):0] o_level
);

  pixel_pair_t      pair_in;
  pixel_pair_t      pair_out;
  logic             ctl_clear;
  logic             pop_req;
  logic             pop_ok;
  logic             fifo_empty;
  logic [CNT_W-1:0] remaining;
  logic [CNT_W-1:0] remaining_nxt;
  logic             done_nxt;
  logic             underflow_nxt;

  assign pair_in   = i_pairData;
  assign o_cpuData = pair_out;

  // Flush and start both empty the buffer and override push/pop.
  always_comb begin
    ctl_clear = i_flush || i_xferStart;
    pop_req   = i_cpuRead && !ctl_clear;
    pop_ok    = pop_req && !fifo_empty;
  end

  gpu_sync_fifo #(
    .DEPTH (DEPTH),
    .W     ($bits(pixel_pair_t))
  ) u_fifo (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_clr      (ctl_clear),
    .i_push     (i_pairValid),
    .i_wdata    (pair_in),
    .o_can_push (o_pairAccept),
    .i_pop      (pop_req),
    .o_rdata    (pair_out),
    .o_empty    (fifo_empty),
    .o_level    (o_level)
  );

  // Next transfer count, done pulse and underflow flag.
  always_comb begin
    remaining_nxt = remaining;
    done_nxt      = 1'b0;
    underflow_nxt = o_underflow;
    if (i_flush) begin
      remaining_nxt = '0;
    end else if (i_xferStart) begin
      remaining_nxt = i_xferWords;
      underflow_nxt = 1'b0;
    end else if (pop_ok) begin
      // Excess words past the end of the transfer leave the count at zero.
      if (remaining != '0) begin
        remaining_nxt = remaining - CNT_W'(1);
        done_nxt      = (remaining == CNT_W'(1));
      end
    end else if (pop_req && remaining != '0) begin
      underflow_nxt = 1'b1;
    end
  end

  // Transfer status registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      remaining   <= '0;
      o_readReady <= 1'b0;
      o_xferDone  <= 1'b0;
      o_underflow <= 1'b0;
    end else begin
      remaining   <= remaining_nxt;
      o_readReady <= (remaining_nxt != '0);
      o_xferDone  <= done_nxt;
      o_underflow <= underflow_nxt;
    end
  end

endmodule

// File: tb/tb_gpu_vramcpu_read_fifo.sv
// Bench for gpu_vramcpu_read_fifo: directed scenarios plus a randomized run
// against a queue-based reference model of the read path.
module tb_gpu_vramcpu_read_fifo;

  localparam int DEPTH = 16;
  localparam int CNT_W = 20;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             xfer_start = 1'b0;
  logic [CNT_W-1:0] xfer_words = '0;
  logic             flush = 1'b0;
  logic             pair_valid = 1'b0;
  logic [31:0]      pair_data = '0;
  logic             pair_accept;
  logic             cpu_read = 1'b0;
  logic [31:0]      cpu_data;
  logic             read_ready;
  logic             xfer_done;
  logic             underflow;
  logic [LW-1:0]    level;

  // Reference model state.
  logic [31:0] exp_q[$];
  int          rem = 0;
  logic [31:0] exp_data = '0;
  logic        exp_uf = 1'b0;
  logic        exp_done = 1'b0;

  int n_chk = 0;
  int n_err = 0;

  gpu_vramcpu_read_fifo #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_xferStart  (xfer_start),
    .i_xferWords  (xfer_words),
    .i_flush      (flush),
    .i_pairValid  (pair_valid),
    .i_pairData   (pair_data),
    .o_pairAccept (pair_accept),
    .i_cpuRead    (cpu_read),
    .o_cpuData    (cpu_data),
    .o_readReady  (read_ready),
    .o_xferDone   (xfer_done),
    .o_underflow  (underflow),
    .o_level      (level)
  );

  // Clock / reset block.
  always #5 clk = ~clk;

  // Driver: one clock edge with the currently driven inputs; the model is
  // advanced from the same inputs, then all strobes return low.
  task automatic tick();
    int sz;
    bit acc;
    sz  = exp_q.size();
    acc = (sz != DEPTH);
    @(posedge clk);
    #1;
    if (rst) begin
      exp_q.delete(); rem = 0; exp_data = '0; exp_uf = 0; exp_done = 0;
    end else if (flush) begin
      exp_q.delete(); rem = 0; exp_done = 0;
    end else if (xfer_start) begin
      exp_q.delete(); rem = int'(xfer_words); exp_uf = 0; exp_done = 0;
    end else begin
      exp_done = 0;
      if (cpu_read) begin
        if (sz > 0) begin
          exp_data = exp_q.pop_front();
          if (rem > 0) begin
            rem--;
            exp_done = (rem == 0);
          end
        end else if (rem > 0) begin
          exp_uf = 1;
        end
      end
      if (pair_valid && acc) exp_q.push_back(pair_data);
    end
    rst = 0; flush = 0; xfer_start = 0; cpu_read = 0; pair_valid = 0;
  endtask

  task automatic start_xfer(input int words);
    xfer_start = 1; xfer_words = CNT_W'(words);
    tick();
  endtask

  task automatic push_word(input logic [31:0] d);
    pair_valid = 1; pair_data = d;
    tick();
  endtask

  task automatic test_reset();
    rst = 1;
    tick();
    n_chk++; if (cpu_data !== 32'h0) begin n_err++; $display("FAIL reset_data: got %h expected 0", cpu_data); end
    n_chk++; if (read_ready !== 1'b0) begin n_err++; $display("FAIL reset_ready: got %b expected 0", read_ready); end
    n_chk++; if (xfer_done !== 1'b0 || underflow !== 1'b0) begin n_err++; $display("FAIL reset_flags: got done=%b uf=%b expected 0 0", xfer_done, underflow); end
    n_chk++; if (level !== '0) begin n_err++; $display("FAIL reset_level: got %0d expected 0", level); end
    n_chk++; if (pair_accept !== 1'b1) begin n_err++; $display("FAIL reset_accept: got %b expected 1", pair_accept); end
  endtask

  task automatic test_basic();
    logic [31:0] w [4];
    w[0] = 32'h1111_2222; w[1] = 32'h2222_3333; w[2] = 32'h3333_4444; w[3] = 32'h4444_5555;
    start_xfer(4);
    n_chk++; if (read_ready !== 1'b1) begin n_err++; $display("FAIL basic_ready_start: got %b expected 1", read_ready); end
    for (int i = 0; i < 4; i++) push_word(w[i]);
    n_chk++; if (level !== LW'(4)) begin n_err++; $display("FAIL basic_level: got %0d expected 4", level); end
    for (int i = 0; i < 4; i++) begin
      cpu_read = 1;
      tick();
      n_chk++; if (cpu_data !== w[i]) begin n_err++; $display("FAIL basic_data%0d: got %h expected %h", i, cpu_data, w[i]); end
      n_chk++; if (xfer_done !== (i == 3)) begin n_err++; $display("FAIL basic_done%0d: got %b expected %b", i, xfer_done, i == 3); end
      n_chk++; if (read_ready !== (i != 3)) begin n_err++; $display("FAIL basic_ready%0d: got %b expected %b", i, read_ready, i != 3); end
    end
    tick();
    n_chk++; if (xfer_done !== 1'b0) begin n_err++; $display("FAIL basic_done_pulse: got %b expected 0", xfer_done); end
  endtask

  task automatic test_full();
    start_xfer(20);
    for (int i = 0; i < DEPTH + 1; i++) push_word(32'hA000_0000 + 32'(i));
    n_chk++; if (level !== LW'(DEPTH)) begin n_err++; $display("FAIL full_level: got %0d expected %0d", level, DEPTH); end
    n_chk++; if (pair_accept !== 1'b0) begin n_err++; $display("FAIL full_accept: got %b expected 0", pair_accept); end
    // Pop and present the rejected 17th word in the same cycle: no bypass.
    cpu_read = 1; pair_valid = 1; pair_data = 32'hA000_0010;
    tick();
    n_chk++; if (cpu_data !== 32'hA000_0000) begin n_err++; $display("FAIL full_pop_data: got %h expected a0000000", cpu_data); end
    n_chk++; if (level !== LW'(DEPTH - 1) || pair_accept !== 1'b1) begin n_err++; $display("FAIL full_after_pop: got level=%0d acc=%b expected %0d 1", level, pair_accept, DEPTH - 1); end
    push_word(32'hA000_0010);
    n_chk++; if (level !== LW'(DEPTH) || pair_accept !== 1'b0) begin n_err++; $display("FAIL full_refill: got level=%0d acc=%b expected %0d 0", level, pair_accept, DEPTH); end
    for (int i = 0; i < DEPTH; i++) begin cpu_read = 1; tick(); end
    n_chk++; if (cpu_data !== 32'hA000_0010) begin n_err++; $display("FAIL full_last_word: got %h expected a0000010", cpu_data); end
    n_chk++; if (read_ready !== 1'b1) begin n_err++; $display("FAIL full_ready: got %b expected 1", read_ready); end
  endtask

  task automatic test_underflow();
    logic [31:0] held;
    held = exp_data;
    start_xfer(2);
    cpu_read = 1;
    tick();
    n_chk++; if (cpu_data !== held) begin n_err++; $display("FAIL uf_data_held: got %h expected %h", cpu_data, held); end
    n_chk++; if (underflow !== 1'b1) begin n_err++; $display("FAIL uf_set: got %b expected 1", underflow); end
    n_chk++; if (read_ready !== 1'b1) begin n_err++; $display("FAIL uf_ready: got %b expected 1", read_ready); end
    push_word(32'hBEEF_0001);
    push_word(32'hBEEF_0002);
    cpu_read = 1; tick();
    n_chk++; if (xfer_done !== 1'b0) begin n_err++; $display("FAIL uf_early_done: got %b expected 0", xfer_done); end
    cpu_read = 1; tick();
    n_chk++; if (xfer_done !== 1'b1 || cpu_data !== 32'hBEEF_0002) begin n_err++; $display("FAIL uf_count_kept: got done=%b data=%h expected 1 beef0002", xfer_done, cpu_data); end
    start_xfer(3);
    n_chk++; if (underflow !== 1'b0) begin n_err++; $display("FAIL uf_clear: got %b expected 0", underflow); end
  endtask

  task automatic test_same_cycle();
    start_xfer(10);
    push_word(32'hC000_000A);
    cpu_read = 1; pair_valid = 1; pair_data = 32'hC000_000B;
    tick();
    n_chk++; if (level !== LW'(1) || cpu_data !== 32'hC000_000A) begin n_err++; $display("FAIL same_lvl1: got level=%0d data=%h expected 1 c000000a", level, cpu_data); end
    cpu_read = 1; tick();
    n_chk++; if (level !== '0 || cpu_data !== 32'hC000_000B) begin n_err++; $display("FAIL same_drain: got level=%0d data=%h expected 0 c000000b", level, cpu_data); end
    cpu_read = 1; pair_valid = 1; pair_data = 32'hC000_000C;
    tick();
    n_chk++; if (level !== LW'(1) || cpu_data !== 32'hC000_000B) begin n_err++; $display("FAIL same_lvl0: got level=%0d data=%h expected 1 c000000b", level, cpu_data); end
    cpu_read = 1; tick();
    n_chk++; if (cpu_data !== 32'hC000_000C) begin n_err++; $display("FAIL same_order: got %h expected c000000c", cpu_data); end
  endtask

  task automatic test_flush();
    logic [31:0] held;
    start_xfer(8);
    for (int i = 0; i < 3; i++) push_word(32'hD000_0000 + 32'(i));
    held = exp_data;
    flush = 1; pair_valid = 1; pair_data = 32'hDEAD_DEAD;
    tick();
    n_chk++; if (level !== '0 || read_ready !== 1'b0) begin n_err++; $display("FAIL flush_state: got level=%0d ready=%b expected 0 0", level, read_ready); end
    n_chk++; if (xfer_done !== 1'b0 || cpu_data !== held) begin n_err++; $display("FAIL flush_keep: got done=%b data=%h expected 0 %h", xfer_done, cpu_data, held); end
    tick();
    n_chk++; if (level !== '0 || xfer_done !== 1'b0) begin n_err++; $display("FAIL flush_after: got level=%0d done=%b expected 0 0", level, xfer_done); end
  endtask

  task automatic test_zero_and_reset();
    start_xfer(0);
    n_chk++; if (read_ready !== 1'b0 || xfer_done !== 1'b0) begin n_err++; $display("FAIL zero_start: got ready=%b done=%b expected 0 0", read_ready, xfer_done); end
    push_word(32'hE000_0001);
    cpu_read = 1; tick();
    n_chk++; if (cpu_data !== 32'hE000_0001 || xfer_done !== 1'b0 || underflow !== 1'b0) begin n_err++; $display("FAIL zero_excess: got data=%h done=%b uf=%b expected e0000001 0 0", cpu_data, xfer_done, underflow); end
    cpu_read = 1; tick();
    n_chk++; if (underflow !== 1'b0 || read_ready !== 1'b0) begin n_err++; $display("FAIL zero_empty_read: got uf=%b ready=%b expected 0 0", underflow, read_ready); end
    start_xfer(5);
    push_word(32'hE000_0002);
    push_word(32'hE000_0003);
    cpu_read = 1; tick();
    rst = 1; tick();
    n_chk++; if (cpu_data !== 32'h0 || read_ready !== 1'b0 || level !== '0) begin n_err++; $display("FAIL rst_mid: got data=%h ready=%b level=%0d expected 0 0 0", cpu_data, read_ready, level); end
    n_chk++; if (xfer_done !== 1'b0 || underflow !== 1'b0 || pair_accept !== 1'b1) begin n_err++; $display("FAIL rst_mid_flags: got done=%b uf=%b acc=%b expected 0 0 1", xfer_done, underflow, pair_accept); end
  endtask

  task automatic test_random();
    logic [LW-1:0] exp_level;
    start_xfer($urandom_range(40, 1));
    for (int c = 0; c < 600; c++) begin
      pair_valid = ($urandom_range(99) < 55);
      pair_data  = $urandom;
      cpu_read   = ($urandom_range(99) < 45);
      flush      = ($urandom_range(63) == 0);
      xfer_start = ($urandom_range(47) == 0);
      xfer_words = CNT_W'($urandom_range(30));
      tick();
      exp_level = LW'(exp_q.size());
      n_chk++;
      if (cpu_data !== exp_data || level !== exp_level || read_ready !== (rem != 0) ||
          xfer_done !== exp_done || underflow !== exp_uf || pair_accept !== (exp_q.size() != DEPTH)) begin
        n_err++;
        $display("FAIL rand_cycle%0d: got data=%h lvl=%0d rdy=%b done=%b uf=%b acc=%b expected %h %0d %b %b %b %b",
                 c, cpu_data, level, read_ready, xfer_done, underflow, pair_accept,
                 exp_data, exp_level, rem != 0, exp_done, exp_uf, exp_q.size() != DEPTH);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_full();
    test_underflow();
    test_same_cycle();
    test_flush();
    test_zero_and_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
